// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// The MEM_ARB_TIMEOUT_EN build option reads ARB_TIMEOUT from this package.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  localparam int MAX_BURST   = 8;
  localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// Stall watchdog for the arbiter: counts cycles with an unanswered memory request.
// It is only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic mem_req,
  input  logic mem_ack,
  output logic timeout
);

  logic [7:0] timer;

  // The 255th unanswered cycle is the one that fires the timeout.
  assign timeout = mem_req & ~mem_ack & (timer == 8'(ARB_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (idle || mem_ack || timeout) begin
      timer <= '0;
    end else if (mem_req) begin
      timer <= timer + 8'd1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter between a single-beat CPU port and a bursting DMA port.
// Define MEM_ARB_TIMEOUT_EN to add the stall watchdog that drives arb_err.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              arb_clk,
  input  logic              arb_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] arb_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              arb_err
);

  state_t     state, state_nx;
  owner_t     last_owner, last_owner_nx;
  logic [2:0] beat_cnt, beat_cnt_nx;
  logic       timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_wdog u_wdog (
    .clk     (arb_clk),
    .rst     (arb_reset),
    .idle    (state == IDLE),
    .mem_req (mem_req),
    .mem_ack (mem_ack),
    .timeout (timeout)
  );
  assign arb_err = timeout;
`else
  assign timeout = 1'b0;
  assign arb_err = 1'b0;
`endif

  // last_owner resets to DMA so the CPU wins the first tie.
  always_ff @(posedge arb_clk or posedge arb_reset) begin
    if (arb_reset) begin
      state      <= IDLE;
      last_owner <= OWNER_DMA;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      beat_cnt   <= beat_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    beat_cnt_nx   = beat_cnt;
    case (state)
      IDLE: begin
        beat_cnt_nx = '0;
        if (cpu_req && dma_req) begin
          state_nx = (last_owner == OWNER_DMA) ? CPU : DMA;
        end else if (cpu_req) begin
          state_nx = CPU;
        end else if (dma_req) begin
          state_nx = DMA;
        end
      end
      CPU: begin
        if (timeout || mem_ack) begin
          state_nx      = IDLE;
          last_owner_nx = OWNER_CPU;
        end
      end
      DMA: begin
        if (timeout || !dma_req) begin
          state_nx      = IDLE;
          last_owner_nx = OWNER_DMA;
        end else if (mem_ack) begin
          if (beat_cnt == 3'(MAX_BURST - 1)) begin
            state_nx      = IDLE;
            last_owner_nx = OWNER_DMA;
          end else begin
            beat_cnt_nx = beat_cnt + 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A timed-out beat is abandoned, so its owner never sees an ack.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    case (state)
      CPU: begin
        mem_req   = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ack   = mem_ack & ~timeout;
      end
      DMA: begin
        mem_req   = dma_req;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_ack   = mem_ack & ~timeout;
      end
      default: ;
    endcase
  end

  assign arb_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table, directed burst/priority sequences,
// and randomized traffic against an ownership-level reference model.
module tb_mem_arb;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              arb_clk = 1'b0;
  logic              arb_reset;
  logic              cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dma_req, dma_we, dma_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] arb_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              arb_err;

  int tests = 0;
  int fails = 0;

  mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .arb_clk   (arb_clk),
    .arb_reset (arb_reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .arb_rdata (arb_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .arb_err   (arb_err)
  );

  always #5 arb_clk = ~arb_clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  typedef struct {
    logic        cpu_req;
    logic        dma_req;
    logic        mem_ack;
    logic        exp_mem_req;
    logic        exp_cpu_ack;
    logic        exp_dma_ack;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_quiet();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  // Leaves the bench at posedge+1 with reset released and the DUT in IDLE.
  task automatic do_reset();
    drive_quiet();
    cpu_req = 1; dma_req = 1; mem_ack = 1; mem_rdata = 32'h1234_5678;
    arb_reset = 1;
    #1;
    check_output("reset mem_req", 32'(mem_req), 32'd0);
    check_output("reset cpu_ack", 32'(cpu_ack), 32'd0);
    check_output("reset dma_ack", 32'(dma_ack), 32'd0);
    check_output("reset arb_err", 32'(arb_err), 32'd0);
    check_output("reset arb_rdata", arb_rdata, 32'h1234_5678);
    repeat (2) @(posedge arb_clk);
    #1;
    drive_quiet();
    arb_reset = 0;
  endtask

  task automatic next_cycle();
    @(posedge arb_clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    cpu_req   = v.cpu_req;
    dma_req   = v.dma_req;
    mem_ack   = v.mem_ack;
    mem_rdata = $urandom;
    @(negedge arb_clk);
  endtask

  // Reference model: who owns the memory, who owned it last, beats served this tenure.
  int m_owner;   // 0 none, 1 cpu, 2 dma
  int m_last;
  int m_beats;

  task automatic model_step();
    case (m_owner)
      0: begin
        m_beats = 0;
        if (cpu_req && dma_req) m_owner = (m_last == 2) ? 1 : 2;
        else if (cpu_req)       m_owner = 1;
        else if (dma_req)       m_owner = 2;
      end
      1: if (mem_ack) begin m_owner = 0; m_last = 1; end
      default: begin
        if (!dma_req) begin
          m_owner = 0; m_last = 2;
        end else if (mem_ack) begin
          m_beats++;
          if (m_beats == 8) begin m_owner = 0; m_last = 2; end
        end
      end
    endcase
  endtask

  initial begin
    int n;
    logic cpu_pending;
    int dma_left;
    logic e_req, e_we, e_cack, e_dack;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;

    vecs[0]  = '{1, 1, 1, 0, 0, 0, 16'h0000};
    vecs[1]  = '{1, 1, 0, 1, 0, 0, 16'h0100};
    vecs[2]  = '{1, 1, 1, 1, 1, 0, 16'h0100};
    vecs[3]  = '{0, 1, 0, 0, 0, 0, 16'h0000};
    vecs[4]  = '{0, 1, 1, 1, 0, 1, 16'h0200};
    vecs[5]  = '{1, 1, 0, 1, 0, 0, 16'h0200};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 16'h0200};
    vecs[7]  = '{1, 1, 0, 0, 0, 0, 16'h0000};
    vecs[8]  = '{1, 1, 1, 1, 1, 0, 16'h0100};
    vecs[9]  = '{1, 1, 0, 0, 0, 0, 16'h0000};
    vecs[10] = '{1, 1, 0, 1, 0, 0, 16'h0200};

    do_reset();
    cpu_addr = 16'h0100; dma_addr = 16'h0200;
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(vecs[i].exp_mem_req));
      check_output($sformatf("vec%0d cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].exp_cpu_ack));
      check_output($sformatf("vec%0d dma_ack", i), 32'(dma_ack), 32'(vecs[i].exp_dma_ack));
      check_output($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      check_output($sformatf("vec%0d arb_rdata", i), arb_rdata, mem_rdata);
      next_cycle();
    end

    // CPU read answered on the third owned cycle.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      mem_ack   = (c == 3);
      mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge arb_clk);
      if (c == 3) begin
        check_output("cpu read ack", 32'(cpu_ack), 32'd1);
        check_output("cpu read rdata", arb_rdata, 32'hDEAD_BEEF);
        check_output("cpu read addr", 32'(mem_addr), 32'h0010);
        check_output("cpu read we", 32'(mem_we), 32'd0);
      end else begin
        check_output($sformatf("cpu wait%0d ack", c), 32'(cpu_ack), 32'd0);
        check_output($sformatf("cpu wait%0d mem_req", c), 32'(mem_req), 32'(c != 0));
      end
      next_cycle();
    end
    cpu_req = 0; mem_ack = 1;
    @(negedge arb_clk);
    check_output("cpu done idle mem_req", 32'(mem_req), 32'd0);
    check_output("cpu done idle ack", 32'(cpu_ack), 32'd0);
    next_cycle();

    // Twelve-beat DMA request split into 8 + 4 with an IDLE gap.
    do_reset();
    n = 0;
    for (int c = 0; c < 15; c++) begin
      dma_req = (n < 12);
      mem_ack = (c < 14);
      @(negedge arb_clk);
      check_output($sformatf("burst c%0d dma_ack", c), 32'(dma_ack),
                   32'(c != 0 && c != 9 && c < 14));
      if (dma_ack) n++;
      next_cycle();
    end
    check_output("burst beat total", 32'(n), 32'd12);

    // CPU arriving at DMA beat 3 waits for burst end plus one IDLE cycle.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      dma_req = (c <= 8);
      cpu_req = (c >= 3);
      mem_ack = 1;
      @(negedge arb_clk);
      check_output($sformatf("wait c%0d dma_ack", c), 32'(dma_ack), 32'(c >= 1 && c <= 8));
      check_output($sformatf("wait c%0d cpu_ack", c), 32'(cpu_ack), 32'(c == 10));
      next_cycle();
    end

    // Reset in the middle of a burst drops the request at once.
    do_reset();
    dma_req = 1; mem_ack = 1;
    @(negedge arb_clk); next_cycle();
    @(negedge arb_clk);
    check_output("pre-abort mem_req", 32'(mem_req), 32'd1);
    #1 arb_reset = 1;
    #1;
    check_output("abort mem_req", 32'(mem_req), 32'd0);
    check_output("abort dma_ack", 32'(dma_ack), 32'd0);
    next_cycle();
    arb_reset = 0;
    @(negedge arb_clk);
    check_output("resume idle mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    @(negedge arb_clk);
    check_output("resume dma mem_req", 32'(mem_req), 32'd1);
    next_cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Unanswered CPU beat times out after 255 requesting cycles.
    do_reset();
    cpu_req = 1; mem_ack = 0;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge arb_clk);
      if (mem_req) n++;
      if (arb_err) begin
        check_output("timeout cpu_ack", 32'(cpu_ack), 32'd0);
        next_cycle();
        break;
      end
      next_cycle();
    end
    check_output("timeout cycle", 32'(n), 32'd255);
    @(negedge arb_clk);
    check_output("timeout idle mem_req", 32'(mem_req), 32'd0);
    check_output("timeout err pulse", 32'(arb_err), 32'd0);
    next_cycle();
`endif

    // Randomized traffic against the ownership model.
    do_reset();
    m_owner = 0; m_last = 2; m_beats = 0;
    cpu_pending = 0; dma_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!cpu_pending && $urandom_range(3) == 0) begin
        cpu_pending = 1;
        cpu_we      = 1'($urandom);
        cpu_addr    = ADDR_W'($urandom);
        cpu_wdata   = $urandom;
      end
      cpu_req = cpu_pending;
      if (dma_left == 0 && $urandom_range(3) == 0) begin
        dma_left = $urandom_range(12, 1);
        dma_we   = 1'($urandom);
      end
      dma_req   = (dma_left > 0);
      dma_wdata = $urandom;
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;

      e_req = (m_owner == 1 && cpu_req) || (m_owner == 2 && dma_req);
      e_we = 0; e_addr = '0; e_wdata = '0;
      if (m_owner == 1) begin e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; end
      if (m_owner == 2) begin e_we = dma_we; e_addr = dma_addr; e_wdata = dma_wdata; end
      e_cack = (m_owner == 1) && mem_ack;
      e_dack = (m_owner == 2) && mem_ack;

      @(negedge arb_clk);
      check_output("rand mem_req", 32'(mem_req), 32'(e_req));
      check_output("rand mem_we", 32'(mem_we), 32'(e_we));
      check_output("rand mem_addr", 32'(mem_addr), 32'(e_addr));
      check_output("rand mem_wdata", mem_wdata, e_wdata);
      check_output("rand cpu_ack", 32'(cpu_ack), 32'(e_cack));
      check_output("rand dma_ack", 32'(dma_ack), 32'(e_dack));
      check_output("rand arb_rdata", arb_rdata, mem_rdata);
      check_output("rand arb_err", 32'(arb_err), 32'd0);

      model_step();
      if (e_cack) cpu_pending = 0;
      if (e_dack && dma_left > 0) begin
        dma_left--;
        dma_addr = dma_addr + 1'b1;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
